// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the memory/I-O responder: FSM state encoding and
// the register offsets of the memory-mapped I/O block.
package mem_io_responder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    RESP     = 2'd2
  } state_t;

  // Register offsets relative to IO_BASE
  localparam int IO_LED     = 0;
  localparam int IO_SW      = 1;
  localparam int IO_TIMER   = 2;
  localparam int IO_SCRATCH = 3;

endpackage

// File: rtl/mem_io_responder_io_regs.sv
// Memory-mapped I/O registers: LED, synchronised switches, free-running timer
// and a scratch register, with a combinational read mux and unmapped-offset
// error decode. Writes take effect on the clock edge where wr_en is high.
module mem_io_responder_io_regs
  import mem_io_responder_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LED_W  = 10,
  parameter int SW_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [SW_W-1:0]   sw,
  output logic [DATA_W-1:0] rd_data,
  output logic              err,
  output logic [LED_W-1:0]  led
);

  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_sync;
  logic [DATA_W-1:0] led_reg;
  logic [DATA_W-1:0] timer;
  logic [DATA_W-1:0] scratch;

  logic sel_led, sel_sw, sel_timer, sel_scratch;

  assign sel_led     = (off == ADDR_W'(IO_LED));
  assign sel_sw      = (off == ADDR_W'(IO_SW));
  assign sel_timer   = (off == ADDR_W'(IO_TIMER));
  assign sel_scratch = (off == ADDR_W'(IO_SCRATCH));

  assign led = led_reg[LED_W-1:0];

  // Register file update; a timer write takes priority over its increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
      led_reg <= '0;
      timer   <= '0;
      scratch <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (wr_en && sel_led) begin
        led_reg <= wdata;
      end
      if (wr_en && sel_timer) begin
        timer <= wdata;
      end else begin
        timer <= timer + DATA_W'(1);
      end
      if (wr_en && sel_scratch) begin
        scratch <= wdata;
      end
    end
  end

  // Read mux; offsets outside the map read as zero and flag an error
  always_comb begin
    rd_data = '0;
    err     = 1'b0;
    if (sel_led) begin
      rd_data = led_reg;
    end else if (sel_sw) begin
      rd_data = DATA_W'(sw_sync);
    end else if (sel_timer) begin
      rd_data = timer;
    end else if (sel_scratch) begin
      rd_data = scratch;
    end else begin
      err = 1'b1;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Target side of the CPU memory port. One request at a time is serviced from
// external block RAM (fixed read latency) or from on-chip I/O registers; the
// ack pulse (and bus_err, for unmapped I/O) is generated on the way out of RESP.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int                ADDR_W  = 16,
  parameter int                DATA_W  = 16,
  parameter logic [ADDR_W-1:0] IO_BASE = 16'hFF00,
  parameter int                RAM_LAT = 1,
  parameter int                LED_W   = 10,
  parameter int                SW_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              bus_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  led
);

  // Last RAM_WAIT count before moving on; RAM data is then valid during RESP
  localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic              io_wr;
  logic              is_io;
  logic [ADDR_W-1:0] io_off;
  logic [DATA_W-1:0] io_rdata;
  logic              io_err;
  logic [1:0]        lat_cnt;
  logic              rd_pend;
  logic              err_pend;

  assign is_io  = (addr >= IO_BASE);
  assign io_off = addr - IO_BASE;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (accept) state_next = is_io ? RESP : RAM_WAIT;
      RAM_WAIT: if (lat_cnt == LAT_LAST) state_next = RESP;
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Acceptance strobes; a request still held high during the ack cycle is not re-accepted
  always_comb begin
    accept = (state == IDLE) && req && !ack;
    io_wr  = accept && is_io && we;
  end

  mem_io_responder_io_regs #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LED_W  (LED_W),
    .SW_W   (SW_W)
  ) u_io_regs (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (io_wr),
    .off     (io_off),
    .wdata   (wdata),
    .sw      (sw),
    .rd_data (io_rdata),
    .err     (io_err),
    .led     (led)
  );

  // Request latching, RAM sequencing, read-data capture and response pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata     <= '0;
      ack       <= 1'b0;
      bus_err   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      lat_cnt   <= '0;
      rd_pend   <= 1'b0;
      err_pend  <= 1'b0;
    end else begin
      ack     <= 1'b0;
      bus_err <= 1'b0;
      ram_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_cnt <= '0;
            if (is_io) begin
              rd_pend  <= 1'b0;
              err_pend <= io_err;
              if (!we) rdata <= io_rdata;
            end else begin
              rd_pend   <= !we;
              err_pend  <= 1'b0;
              ram_addr  <= addr;
              ram_wdata <= wdata;
              ram_we    <= we;
            end
          end
        end
        RAM_WAIT: lat_cnt <= lat_cnt + 2'd1;
        RESP: begin
          ack     <= 1'b1;
          bus_err <= err_pend;
          if (rd_pend) rdata <= ram_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: the stimulus process computes each
// expected response from a behavioural model and queues it; a monitor pops
// and compares whenever ack (or ram_we) is seen.
module tb_mem_io_responder;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        bus_err;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [9:0]  sw;
  logic [9:0]  led;

  int checks = 0;
  int errors = 0;
  int cyc;

  mem_io_responder #(
    .ADDR_W (16), .DATA_W (16), .IO_BASE (16'hFF00),
    .RAM_LAT (1), .LED_W (10), .SW_W (10)
  ) dut (
    .clk (clk), .reset (reset), .req (req), .we (we), .addr (addr),
    .wdata (wdata), .rdata (rdata), .ack (ack), .bus_err (bus_err),
    .ram_addr (ram_addr), .ram_we (ram_we), .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata), .sw (sw), .led (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedges since the last reset release (the DUT timer counts the same edges)
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // External block RAM, one-cycle registered read
  bit [15:0] ram_mem [0:1023];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr[9:0]] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr[9:0]];
  end

  // Reference model state
  bit [15:0]   model_mem [int];
  logic [15:0] led_full_m;
  logic [15:0] scratch_m;
  logic [15:0] last_rd_m;
  int          tmr_base;
  int          tmr_ref;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic        w;
    logic [15:0] rdata;
    logic        err;
    logic [9:0]  led;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  exp_t sb_q[$];
  wr_t  wr_q[$];
  exp_t mon_e;
  wr_t  mon_w;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic logic [15:0] model_ram_rd(input logic [15:0] a);
    if (model_mem.exists(int'(a))) return model_mem[int'(a)];
    return 16'h0000;
  endfunction

  // Timer value during the cycle following posedge number c
  function automatic logic [15:0] timer_at(input int c);
    return 16'(tmr_base + (c - tmr_ref));
  endfunction

  task automatic model_reset();
    led_full_m = 16'h0;
    scratch_m  = 16'h0;
    last_rd_m  = 16'h0;
    tmr_base   = 0;
    tmr_ref    = 0;
  endtask

  // One request: raise req, predict the response, wait (bounded) for ack
  task automatic do_txn(input logic [15:0] a, input logic w, input logic [15:0] d, input bit drop);
    int   c;
    int   acc;
    int   lat;
    int   off;
    logic err;
    bit   got;
    exp_t e;
    wr_t  wr;
    @(negedge clk);
    addr  = a;
    we    = w;
    wdata = d;
    req   = 1'b1;
    c     = cyc;
    acc   = c + 1;
    err   = 1'b0;
    if (a >= 16'hFF00) begin
      lat = 1;
      off = int'(a - 16'hFF00);
      err = (off > 3);
      if (w) begin
        if (off == 0) led_full_m = d;
        else if (off == 2) begin tmr_base = int'(d); tmr_ref = acc; end
        else if (off == 3) scratch_m = d;
      end else begin
        case (off)
          0:       last_rd_m = led_full_m;
          1:       last_rd_m = {6'b0, sw};
          2:       last_rd_m = timer_at(c);
          3:       last_rd_m = scratch_m;
          default: last_rd_m = 16'h0000;
        endcase
      end
    end else begin
      lat = 2;
      if (w) begin
        model_mem[int'(a)] = d;
        wr.cyc = acc; wr.addr = a; wr.data = d;
        wr_q.push_back(wr);
      end else begin
        last_rd_m = model_ram_rd(a);
      end
    end
    e.cyc = acc + lat; e.addr = a; e.w = w;
    e.rdata = last_rd_m; e.err = err; e.led = led_full_m[9:0];
    sb_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("led_after_accept", 32'(led), 32'(led_full_m[9:0]));
        if (drop) req = 1'b0;
      end
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    req = 1'b0;
    chk("ack_within_budget", 32'(got), 32'd1);
  endtask

  // Monitor: compare every ack and every RAM write strobe against the queues
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (ack) begin
          if (sb_q.size() == 0) begin
            chk("spurious_ack", 32'(ack), 32'd0);
          end else begin
            mon_e = sb_q.pop_front();
            chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
            chk("rdata", 32'(rdata), 32'(mon_e.rdata));
            chk("bus_err", 32'(bus_err), 32'(mon_e.err));
            chk("led", 32'(led), 32'(mon_e.led));
            $display("txn addr=%h we=%0d rdata=%h bus_err=%0d led=%h cycle=%0d",
                     mon_e.addr, mon_e.w, rdata, bus_err, led, cyc);
          end
        end else if (bus_err) begin
          chk("bus_err_without_ack", 32'(bus_err), 32'd0);
        end
        if (ram_we) begin
          if (wr_q.size() == 0) begin
            chk("unexpected_ram_we", 32'(ram_we), 32'd0);
          end else begin
            mon_w = wr_q.pop_front();
            chk("ram_we_cycle", 32'(cyc), 32'(mon_w.cyc));
            chk("ram_addr", 32'(ram_addr), 32'(mon_w.addr));
            chk("ram_wdata", 32'(ram_wdata), 32'(mon_w.data));
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int          r;
    logic [15:0] a;
    reset = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 16'h0;
    wdata = 16'h0;
    sw    = 10'h0;
    model_reset();
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rdata", 32'(rdata), 32'd0);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_bus_err", 32'(bus_err), 32'd0);
    chk("reset_ram_we", 32'(ram_we), 32'd0);
    chk("reset_ram_addr", 32'(ram_addr), 32'd0);
    chk("reset_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("reset_led", 32'(led), 32'd0);
    reset = 1'b1;

    // RAM write then read back
    do_txn(16'h0010, 1'b1, 16'hBEEF, 1'b0);
    do_txn(16'h0010, 1'b0, 16'h0000, 1'b0);
    // LED write
    do_txn(16'hFF00, 1'b1, 16'h03FF, 1'b0);
    // Switch read through the synchroniser, write to SW ignored
    @(negedge clk);
    sw = 10'h155;
    repeat (3) @(negedge clk);
    do_txn(16'hFF01, 1'b0, 16'h0000, 1'b0);
    do_txn(16'hFF01, 1'b1, 16'h1234, 1'b0);
    do_txn(16'hFF01, 1'b0, 16'h0000, 1'b0);
    // Timer wrap
    do_txn(16'hFF02, 1'b1, 16'hFFFE, 1'b0);
    repeat (2) @(negedge clk);
    do_txn(16'hFF02, 1'b0, 16'h0000, 1'b0);
    // Unmapped I/O read with req dropped right after acceptance
    do_txn(16'hFF07, 1'b0, 16'h0000, 1'b1);
    // Scratch, RAM/I-O boundary, unmapped write
    do_txn(16'hFF03, 1'b1, 16'hA5A5, 1'b0);
    do_txn(16'hFF03, 1'b0, 16'h0000, 1'b0);
    do_txn(16'hFEFF, 1'b1, 16'h1357, 1'b0);
    do_txn(16'hFEFF, 1'b0, 16'h0000, 1'b0);
    do_txn(16'hFFFF, 1'b1, 16'h7777, 1'b0);

    // Reset asserted while a RAM read is waiting on the RAM
    do_txn(16'hFF00, 1'b1, 16'h02AA, 1'b0);
    do_txn(16'hFF00, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    addr = 16'h0010;
    we   = 1'b0;
    req  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset_ack", 32'(ack), 32'd0);
    chk("midreset_ram_we", 32'(ram_we), 32'd0);
    chk("midreset_rdata", 32'(rdata), 32'd0);
    chk("midreset_led", 32'(led), 32'd0);
    req = 1'b0;
    sb_q.delete();
    wr_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_txn(16'h0010, 1'b0, 16'h0000, 1'b0);

    // Randomised traffic
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      a = 16'($urandom_range(0, 511));
      else if (r == 4) a = 16'hFEFF;
      else if (r <= 8) a = 16'hFF00 + 16'($urandom_range(0, 3));
      else             a = 16'hFF00 + 16'($urandom_range(4, 255));
      do_txn(a, 1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        sw = 10'($urandom);
        repeat (3) @(negedge clk);
      end
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    chk("ram_writes_drained", 32'(wr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "time limit");
  end

endmodule
